// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings and small helpers used across the interconnect.
// Every slave port and arbiter imports these rather than redefining them.
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Width of a master index; never zero so a single-master build still has a port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ahb3lite_interconnect_arbiter.sv
// Combinational priority arbiter with round-robin tie-break.
// Among requesters at the highest priority, the first index after i_pointer wins.
module ahb3lite_interconnect_arbiter
    import ahb3lite_pkg::*;
#(
    parameter  int MASTERS = 3,
    localparam int IW      = idx_width(MASTERS)
) (
    input  logic [MASTERS-1:0] i_request,
    input  logic [2:0]         i_priority [MASTERS],
    input  logic [IW-1:0]      i_pointer,
    output logic [MASTERS-1:0] o_winner
);

    logic [2:0]         w_max;
    logic [MASTERS-1:0] w_cand;
    logic               w_found;

    always_comb begin
        w_max   = '0;
        w_cand  = '0;
        o_winner = '0;
        w_found = 1'b0;
        for (int i = 0; i < MASTERS; i++)
            if (i_request[i] && (i_priority[i] > w_max)) w_max = i_priority[i];
        for (int i = 0; i < MASTERS; i++)
            w_cand[i] = i_request[i] && (i_priority[i] == w_max);
        // First pass covers indices after the pointer, second pass wraps to the start.
        for (int i = 0; i < MASTERS; i++)
            if (!w_found && w_cand[i] && (i > int'(i_pointer))) begin
                o_winner[i] = 1'b1;
                w_found     = 1'b1;
            end
        for (int i = 0; i < MASTERS; i++)
            if (!w_found && w_cand[i]) begin
                o_winner[i] = 1'b1;
                w_found     = 1'b1;
            end
    end

endmodule

// File: rtl/ahb3lite_interconnect_slave_port.sv
// Slave-side port of an AHB3-Lite interconnect: arbitrates masters for one slave,
// muxes address/data phases from the owners and broadcasts the slave response.
module ahb3lite_interconnect_slave_port
    import ahb3lite_pkg::*;
#(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int MASTERS    = 3
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic [2:0]            mstpriority  [MASTERS],
    input  logic [MASTERS-1:0]    mstHSEL,
    input  logic [HADDR_SIZE-1:0] mstHADDR     [MASTERS],
    input  logic [HDATA_SIZE-1:0] mstHWDATA    [MASTERS],
    input  logic [MASTERS-1:0]    mstHWRITE,
    input  logic [2:0]            mstHSIZE     [MASTERS],
    input  logic [2:0]            mstHBURST    [MASTERS],
    input  logic [3:0]            mstHPROT     [MASTERS],
    input  logic [1:0]            mstHTRANS    [MASTERS],
    input  logic [MASTERS-1:0]    mstHMASTLOCK,
    input  logic [MASTERS-1:0]    mstHREADY,
    input  logic [MASTERS-1:0]    can_switch,
    output logic [MASTERS-1:0]    master_granted,
    output logic [HDATA_SIZE-1:0] mstHRDATA,
    output logic                  mstHREADYOUT,
    output logic                  mstHRESP,
    output logic                  HSEL,
    output logic [HADDR_SIZE-1:0] HADDR,
    output logic [HDATA_SIZE-1:0] HWDATA,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [1:0]            HTRANS,
    output logic                  HMASTLOCK,
    input  logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HREADYOUT,
    input  logic                  HRESP,
    output logic                  HREADY
);

    localparam int IW = idx_width(MASTERS);

    logic [MASTERS-1:0] r_grant;
    logic [IW-1:0]      r_gidx;
    logic [IW-1:0]      r_pointer;
    logic [IW-1:0]      r_dp_idx;
    logic               r_dp_valid;

    logic [MASTERS-1:0] w_win;
    logic [IW-1:0]      w_win_idx;
    logic               w_owned;
    logic               w_may_switch;
    logic               w_update;

    ahb3lite_interconnect_arbiter #(.MASTERS(MASTERS)) u_arbiter (
        .i_request  (mstHSEL),
        .i_priority (mstpriority),
        .i_pointer  (r_pointer),
        .o_winner   (w_win)
    );

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < MASTERS; i++)
            if (w_win[i]) w_win_idx = IW'(i);
    end

    assign w_owned      = |r_grant;
    assign w_may_switch = !w_owned || !mstHSEL[r_gidx]
                        || (can_switch[r_gidx] && !mstHMASTLOCK[r_gidx]);
    // Gating on HREADYOUT also pushes any switch past the first ERROR cycle.
    assign w_update     = HREADYOUT && w_may_switch;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_grant    <= '0;
            r_gidx     <= '0;
            r_pointer  <= '0;
            r_dp_idx   <= '0;
            r_dp_valid <= 1'b0;
        end else begin
            if (w_update) begin
                r_grant <= w_win;
                r_gidx  <= w_win_idx;
                if ((|w_win) && (w_win != r_grant)) r_pointer <= w_win_idx;
            end
            if (HREADYOUT) begin
                r_dp_idx   <= r_gidx;
                r_dp_valid <= HSEL && (HTRANS != HTRANS_IDLE);
            end
        end
    end

    always_comb begin
        HSEL      = w_owned && mstHSEL[r_gidx];
        HADDR     = '0;
        HWRITE    = 1'b0;
        HSIZE     = '0;
        HBURST    = HBURST_SINGLE;
        HPROT     = '0;
        HMASTLOCK = 1'b0;
        if (w_owned) begin
            HADDR     = mstHADDR[r_gidx];
            HWRITE    = mstHWRITE[r_gidx];
            HSIZE     = mstHSIZE[r_gidx];
            HBURST    = mstHBURST[r_gidx];
            HPROT     = mstHPROT[r_gidx];
            HMASTLOCK = mstHMASTLOCK[r_gidx];
        end
        HTRANS = HSEL ? mstHTRANS[r_gidx] : HTRANS_IDLE;
        HWDATA = r_dp_valid ? mstHWDATA[r_dp_idx] : '0;
        HREADY = r_dp_valid ? mstHREADY[r_dp_idx] : HREADYOUT;
    end

    assign master_granted = r_grant;
    assign mstHRDATA      = HRDATA;
    assign mstHREADYOUT   = HREADYOUT;
    assign mstHRESP       = HRESP;

endmodule

// File: tb/tb_ahb3lite_interconnect_slave_port.sv
// Bench for the interconnect slave port: directed scenarios then random traffic,
// all checked against a transaction-level model of ownership and data phase.
module tb_ahb3lite_interconnect_slave_port;
  import ahb3lite_pkg::*;

  localparam int M  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic HRESET;

  logic [2:0]    mstpriority [M];
  logic [M-1:0]  mstHSEL, mstHWRITE, mstHMASTLOCK, mstHREADY, can_switch;
  logic [AW-1:0] mstHADDR [M];
  logic [DW-1:0] mstHWDATA [M];
  logic [2:0]    mstHSIZE [M];
  logic [2:0]    mstHBURST [M];
  logic [3:0]    mstHPROT [M];
  logic [1:0]    mstHTRANS [M];
  logic [M-1:0]  master_granted;
  logic [DW-1:0] mstHRDATA;
  logic          mstHREADYOUT, mstHRESP;
  logic          HSEL, HWRITE, HMASTLOCK, HREADY;
  logic [AW-1:0] HADDR;
  logic [DW-1:0] HWDATA;
  logic [2:0]    HSIZE, HBURST;
  logic [3:0]    HPROT;
  logic [1:0]    HTRANS;
  logic [DW-1:0] HRDATA;
  logic          HREADYOUT, HRESP;

  ahb3lite_interconnect_slave_port #(.HADDR_SIZE(AW), .HDATA_SIZE(DW), .MASTERS(M)) dut (
    .HCLK(clk), .HRESET(HRESET),
    .mstpriority(mstpriority), .mstHSEL(mstHSEL), .mstHADDR(mstHADDR), .mstHWDATA(mstHWDATA),
    .mstHWRITE(mstHWRITE), .mstHSIZE(mstHSIZE), .mstHBURST(mstHBURST), .mstHPROT(mstHPROT),
    .mstHTRANS(mstHTRANS), .mstHMASTLOCK(mstHMASTLOCK), .mstHREADY(mstHREADY),
    .can_switch(can_switch), .master_granted(master_granted),
    .mstHRDATA(mstHRDATA), .mstHREADYOUT(mstHREADYOUT), .mstHRESP(mstHRESP),
    .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HREADY(HREADY)
  );

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [M-1:0] exp_q[$];
  int m_owner;   // -1: no owner
  int m_last;    // last master that newly won ownership
  int m_dp;      // -1: no valid data phase

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_arb();
    int best_p = -1;
    int w = -1;
    for (int k = 1; k <= M; k++) begin
      int i = (m_last + k) % M;
      if (mstHSEL[i] && (int'(mstpriority[i]) > best_p)) begin
        best_p = int'(mstpriority[i]);
        w = i;
      end
    end
    return w;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 0;
    m_dp    = -1;
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  task automatic model_update();
    logic [M-1:0] g;
    int new_dp;
    if (HRESET) begin
      m_owner = -1;
      m_last  = 0;
      m_dp    = -1;
    end else if (HREADYOUT) begin
      new_dp = (m_owner >= 0 && mstHSEL[m_owner] && mstHTRANS[m_owner] != HTRANS_IDLE) ? m_owner : -1;
      if (m_owner < 0 || !mstHSEL[m_owner] || (can_switch[m_owner] && !mstHMASTLOCK[m_owner])) begin
        int w;
        w = model_arb();
        if (w >= 0 && w != m_owner) m_last = w;
        m_owner = w;
      end
      m_dp = new_dp;
    end
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    exp_q.push_back(g);
  endtask

  task automatic check_outputs();
    logic [M-1:0] eg;
    logic ehsel;
    logic [1:0] etr;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL exp_q: expected queue empty at %0t", $time);
      eg = '0;
    end else begin
      eg = exp_q.pop_front();
    end
    check_val("grant", 64'(master_granted), 64'(eg));
    ehsel = (m_owner >= 0) ? mstHSEL[m_owner] : 1'b0;
    etr   = ehsel ? mstHTRANS[m_owner] : HTRANS_IDLE;
    check_val("hsel", 64'(HSEL), 64'(ehsel));
    check_val("htrans", 64'(HTRANS), 64'(etr));
    if (m_owner >= 0) begin
      check_val("haddr", 64'(HADDR), 64'(mstHADDR[m_owner]));
      check_val("hwrite", 64'(HWRITE), 64'(mstHWRITE[m_owner]));
      check_val("hsize", 64'(HSIZE), 64'(mstHSIZE[m_owner]));
      check_val("hburst", 64'(HBURST), 64'(mstHBURST[m_owner]));
      check_val("hprot", 64'(HPROT), 64'(mstHPROT[m_owner]));
      check_val("hmastlock", 64'(HMASTLOCK), 64'(mstHMASTLOCK[m_owner]));
    end
    check_val("hwdata", 64'(HWDATA), (m_dp >= 0) ? 64'(mstHWDATA[m_dp]) : 64'd0);
    check_val("hready", 64'(HREADY), (m_dp >= 0) ? 64'(mstHREADY[m_dp]) : 64'(HREADYOUT));
    check_val("hrdata_bcast", 64'(mstHRDATA), 64'(HRDATA));
    check_val("hresp_bcast", 64'(mstHRESP), 64'(HRESP));
    check_val("hreadyout_bcast", 64'(mstHREADYOUT), 64'(HREADYOUT));
  endtask

  // driver tasks: called at a negedge with inputs already set
  task automatic cycle();
    #1;
    check_outputs();
    model_update();
    @(negedge clk);
  endtask

  task automatic set_idle();
    for (int i = 0; i < M; i++) begin
      mstpriority[i] = '0;
      mstHADDR[i]    = 32'h1000_0000 + 32'(i) * 32'h100;
      mstHWDATA[i]   = 32'hC0DE_0000 + 32'(i);
      mstHSIZE[i]    = 3'd2;
      mstHBURST[i]   = HBURST_SINGLE;
      mstHPROT[i]    = 4'h3;
      mstHTRANS[i]   = HTRANS_NONSEQ;
    end
    mstHSEL = '0; mstHWRITE = '0; mstHMASTLOCK = '0; mstHREADY = '1; can_switch = '0;
    HREADYOUT = 1'b1; HRESP = HRESP_OKAY; HRDATA = $urandom();
  endtask

  initial begin
    set_idle();
    HRESET = 1'b1;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    HRESET = 1'b0;

    // priority: M2 (5) beats M0 (2)
    mstHSEL = 3'b101; mstpriority[0] = 3'd2; mstpriority[2] = 3'd5;
    mstHADDR[2] = 32'hA2A2_0000;
    cycle();
    check_val("prio_grant", 64'(master_granted), 64'(3'b100));
    check_val("prio_haddr", 64'(HADDR), 64'h0000_0000_A2A2_0000);

    // round-robin at equal priority
    mstHSEL = 3'b111; can_switch = 3'b111;
    for (int i = 0; i < M; i++) mstpriority[i] = 3'd3;
    cycle(); check_val("rr_1", 64'(master_granted), 64'(3'b001));
    cycle(); check_val("rr_2", 64'(master_granted), 64'(3'b010));
    cycle(); check_val("rr_3", 64'(master_granted), 64'(3'b100));
    cycle(); check_val("rr_4", 64'(master_granted), 64'(3'b001));

    // lock holds M1 against a priority-7 requester
    mstHSEL = 3'b010;
    cycle(); check_val("lock_own", 64'(master_granted), 64'(3'b010));
    mstHSEL = 3'b110; mstpriority[2] = 3'd7; mstHMASTLOCK = 3'b010;
    for (int k = 0; k < 3; k++) begin
      cycle(); check_val("lock_hold", 64'(master_granted), 64'(3'b010));
    end
    mstHMASTLOCK = '0;
    cycle(); check_val("lock_release", 64'(master_granted), 64'(3'b100));

    // wait states during an INCR4 write from M0
    set_idle(); mstHSEL = 3'b001; can_switch = 3'b111;
    cycle(); check_val("ws_own", 64'(master_granted), 64'(3'b001));
    mstHSEL = 3'b011; mstpriority[1] = 3'd7; can_switch = 3'b000;
    mstHBURST[0] = HBURST_INCR4; mstHWRITE = 3'b001; mstHWDATA[0] = 32'hD000_0000;
    cycle();
    mstHTRANS[0] = HTRANS_SEQ; HREADYOUT = 1'b0; can_switch = 3'b111;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_val("ws_grant", 64'(master_granted), 64'(3'b001));
      check_val("ws_hwdata", 64'(HWDATA), 64'h0000_0000_D000_0000);
    end
    HREADYOUT = 1'b1; can_switch = 3'b000;
    for (int k = 0; k < 2; k++) begin
      cycle(); check_val("ws_burst", 64'(master_granted), 64'(3'b001));
    end
    can_switch = 3'b001;
    cycle(); check_val("ws_switch", 64'(master_granted), 64'(3'b010));

    // two-cycle ERROR response defers the switch
    set_idle(); mstHSEL = 3'b011; mstpriority[0] = 3'd7;
    cycle(); check_val("err_own", 64'(master_granted), 64'(3'b010));
    HRESP = HRESP_ERROR; HREADYOUT = 1'b0; can_switch = 3'b010;
    #1; check_val("err1_hresp", 64'(mstHRESP), 64'd1);
    cycle(); check_val("err1_grant", 64'(master_granted), 64'(3'b010));
    HREADYOUT = 1'b1;
    #1; check_val("err2_hresp", 64'(mstHRESP), 64'd1);
    cycle(); check_val("err2_grant", 64'(master_granted), 64'(3'b001));

    // reset in the middle of a NONSEQ
    set_idle(); mstHSEL = 3'b001; can_switch = 3'b111;
    cycle();
    HRESET = 1'b1;
    cycle(); cycle();
    HRESET = 1'b0;
    #1;
    check_val("rst_grant", 64'(master_granted), 64'd0);
    check_val("rst_htrans", 64'(HTRANS), 64'(HTRANS_IDLE));
    check_val("rst_hsel", 64'(HSEL), 64'd0);
    cycle();

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < M; i++) begin
        mstHSEL[i]      = ($urandom_range(0, 9) < 7);
        mstpriority[i]  = 3'($urandom_range(0, 3));
        mstHADDR[i]     = $urandom();
        mstHWDATA[i]    = $urandom();
        mstHWRITE[i]    = 1'($urandom_range(0, 1));
        mstHSIZE[i]     = 3'($urandom_range(0, 2));
        mstHBURST[i]    = 3'($urandom_range(0, 7));
        mstHPROT[i]     = 4'($urandom_range(0, 15));
        mstHTRANS[i]    = 2'($urandom_range(0, 3));
        mstHMASTLOCK[i] = ($urandom_range(0, 9) < 2);
        mstHREADY[i]    = ($urandom_range(0, 9) < 8);
        can_switch[i]   = ($urandom_range(0, 9) < 6);
      end
      HREADYOUT = ($urandom_range(0, 9) < 8);
      HRESP     = ($urandom_range(0, 9) == 0);
      HRDATA    = $urandom();
      HRESET    = ($urandom_range(0, 99) == 0);
      cycle();
    end

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
